// File: rtl/conv_enc_pkg.sv
// rtl/conv_enc_pkg.sv - shared types and constants for the streaming convolutional encoder
package conv_enc_pkg;

   // Frame phase: data bits from upstream, then the zero-tail flush
   typedef enum logic [0:0] {
      CONV_DATA = 1'b0,
      CONV_TAIL = 1'b1
   } conv_state_e;

   // Generators of the legacy (2,1,4) encoder: out_sym[1] taps 1111, out_sym[0] taps 1101
   localparam logic [7:0] CONV_GEN_K4_N2 = 8'b1111_1101;

   // Width of a counter that must hold the K-1 tail encodes of a frame
   function automatic int conv_tail_cnt_w(input int k);
      return $clog2(k);
   endfunction

endpackage

// File: rtl/conv_encoder_stream_if.sv
// rtl/conv_encoder_stream_if.sv - bit-in / symbol-out handshake bundle of the encoder
interface conv_encoder_stream_if #(
   parameter int N = 2
);
   logic         in_valid;
   logic         in_ready;
   logic         in_bit;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] out_sym;
   logic         out_last;

   // Environment side: bit source upstream and symbol sink downstream
   modport master (
      output in_valid, in_bit, in_last, out_ready,
      input  in_ready, out_valid, out_sym, out_last
   );

   // Encoder side
   modport slave (
      input  in_valid, in_bit, in_last, out_ready,
      output in_ready, out_valid, out_sym, out_last
   );
endinterface

// File: rtl/conv_enc_parity.sv
// rtl/conv_enc_parity.sv - combinational generator taps over the encoder window
module conv_enc_parity
   import conv_enc_pkg::*;
#(
   parameter int             K   = 4,
   parameter int             N   = 2,
   parameter logic [N*K-1:0] GEN = CONV_GEN_K4_N2
) (
   input  logic [K-1:0] win,
   output logic [N-1:0] sym
);

   // Each output bit is the XOR of the window bits its generator selects
   always_comb begin
      sym = '0;
      for (int j = 0; j < N; j++) begin
         sym[j] = ^(GEN[j*K +: K] & win);
      end
   end

endmodule

// File: rtl/conv_encoder_stream.sv
// rtl/conv_encoder_stream.sv - streaming rate 1/N encoder; CONV_ENC_TAIL_EN enables zero-tail frames
module conv_encoder_stream
   import conv_enc_pkg::*;
#(
   parameter int             K   = 4,
   parameter int             N   = 2,
   parameter logic [N*K-1:0] GEN = CONV_GEN_K4_N2
) (
   input  logic                 clk,
   input  logic                 reset,
   conv_encoder_stream_if.slave bus
);

   logic [K-2:0] sr;          // sr[K-2] is the newest bit, sr[0] the oldest
   logic [N-1:0] sym_q;
   logic         valid_q;
   logic         last_q;

   logic         slot_free;
   logic         in_ready;
   logic         in_fire;
   logic         encode;
   logic         enc_u;
   logic         enc_last;
   logic         enc_clear;
   logic [K-1:0] win;
   logic [N-1:0] enc_sym;

   // The one-deep output register can take a new symbol when empty or draining
   assign slot_free = !valid_q || bus.out_ready;
   assign in_fire   = bus.in_valid && in_ready;
   assign win       = {enc_u, sr};

   conv_enc_parity #(
      .K   (K),
      .N   (N),
      .GEN (GEN)
   ) u_parity (
      .win (win),
      .sym (enc_sym)
   );

`ifdef CONV_ENC_TAIL_EN
   localparam int         CW     = conv_tail_cnt_w(K);
   localparam logic [0:0] S_DATA = CONV_DATA;
   localparam logic [0:0] S_TAIL = CONV_TAIL;

   logic [0:0]    state;
   logic [CW-1:0] tail_cnt;

   // In TAIL the encoder feeds zeros, blocks upstream and encodes whenever the slot frees
   always_comb begin
      in_ready  = (state == S_DATA) && slot_free;
      enc_u     = (state == S_DATA) ? bus.in_bit : 1'b0;
      encode    = in_fire || ((state == S_TAIL) && slot_free);
      enc_last  = (state == S_TAIL) && (tail_cnt == CW'(1));
      enc_clear = 1'b0;
   end

   // Frame FSM: the last data bit arms K-1 tail encodes, the final one returns to DATA
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_DATA;
         tail_cnt <= '0;
      end else if (state == S_DATA) begin
         if (in_fire && bus.in_last) begin
            state    <= S_TAIL;
            tail_cnt <= CW'(K - 1);
         end
      end else if (encode) begin
         tail_cnt <= tail_cnt - CW'(1);
         if (tail_cnt == CW'(1)) begin
            state <= S_DATA;
         end
      end
   end
`else
   // Without a tail the frame ends on its last data symbol and the register restarts from zero
   always_comb begin
      in_ready  = slot_free;
      enc_u     = bus.in_bit;
      encode    = in_fire;
      enc_last  = bus.in_last;
      enc_clear = bus.in_last;
   end
`endif

   // Shift register and output symbol register; an encode always lands in a free slot
   always_ff @(posedge clk) begin
      if (reset) begin
         sr      <= '0;
         sym_q   <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (encode) begin
         sym_q   <= enc_sym;
         last_q  <= enc_last;
         valid_q <= 1'b1;
         sr      <= enc_clear ? '0 : win[K-1:1];
      end else if (slot_free) begin
         valid_q <= 1'b0;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = valid_q;
   assign bus.out_sym   = sym_q;
   assign bus.out_last  = last_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// tb/tb_conv_encoder_stream.sv - directed self-checking bench for conv_encoder_stream
`timescale 1ns/1ps
module tb_conv_encoder_stream;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;

   logic [1:0] got_sym  [$];
   logic       got_last [$];
   int         got_cyc  [$];

   conv_encoder_stream_if #(.N(2)) bus ();

   conv_encoder_stream #(
      .K   (4),
      .N   (2),
      .GEN (8'b1111_1101)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every symbol that will be accepted at the coming rising edge
   always @(negedge clk) begin
      if (reset === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         got_sym.push_back(bus.out_sym);
         got_last.push_back(bus.out_last);
         got_cyc.push_back(cyc);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mon();
      got_sym.delete();
      got_last.delete();
      got_cyc.delete();
   endtask

   task automatic send_bit(input logic b, input logic l, output int waited);
      bus.in_valid = 1'b1;
      bus.in_bit   = b;
      bus.in_last  = l;
      waited = 0;
      @(negedge clk);
      while (bus.in_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic wait_count(input int n, output logic ok);
      int t;
      t = 0;
      while (got_sym.size() < n && t < 100) begin
         sync();
         t++;
      end
      repeat (2) sync();
      ok = (got_sym.size() == n);
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.in_bit    = 1'b0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
      checks++;
      if (bus.out_sym !== 2'b00) begin failures++; $display("FAIL reset_out_sym got=%b exp=00", bus.out_sym); end
      checks++;
      if (bus.out_last !== 1'b0) begin failures++; $display("FAIL reset_out_last got=%b exp=0", bus.out_last); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
   endtask

   task automatic test_in_last_ignored();
      sync();
      bus.in_valid = 1'b0;
      bus.in_bit   = 1'b1;
      bus.in_last  = 1'b1;
      sync();
      sync();
      bus.in_bit  = 1'b0;
      bus.in_last = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
         failures++;
         $display("FAIL last_no_valid got in_ready=%b out_valid=%b exp in_ready=1 out_valid=0", bus.in_ready, bus.out_valid);
      end
   endtask

   task automatic test_single_bit();
      int w;
`ifdef CONV_ENC_TAIL_EN
      logic [1:0] es [4];
      logic [3:0] el;
      es = '{2'b11, 2'b11, 2'b10, 2'b11};
      el = 4'b1000;
      clear_mon();
      sync();
      send_bit(1'b1, 1'b1, w);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.out_valid, bus.out_sym, bus.out_last} !== {1'b1, es[i], el[i]}) begin
            failures++;
            $display("FAIL single_sym[%0d] got v=%b s=%b l=%b exp v=1 s=%b l=%b", i, bus.out_valid, bus.out_sym, bus.out_last, es[i], el[i]);
         end
         checks++;
         if (bus.in_ready !== el[i]) begin
            failures++;
            $display("FAIL single_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, el[i]);
         end
         sync();
      end
`else
      clear_mon();
      sync();
      send_bit(1'b1, 1'b1, w);
      @(negedge clk);
      checks++;
      if ({bus.out_valid, bus.out_sym, bus.out_last, bus.in_ready} !== 5'b1_11_1_1) begin
         failures++;
         $display("FAIL single_sym got v=%b s=%b l=%b rdy=%b exp v=1 s=11 l=1 rdy=1", bus.out_valid, bus.out_sym, bus.out_last, bus.in_ready);
      end
      sync();
`endif
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL single_idle got out_valid=%b in_ready=%b exp 0/1", bus.out_valid, bus.in_ready);
      end
   endtask

   task automatic test_frame();
      logic [1:0] es [7];
      logic [6:0] el;
      int         n;
      int         w;
      int         wsum;
      logic       ok;
      logic       consec;
`ifdef CONV_ENC_TAIL_EN
      es = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
      el = 7'b1000000;
      n  = 7;
`else
      es = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
      el = 7'b0001000;
      n  = 4;
`endif
      clear_mon();
      sync();
      wsum = 0;
      send_bit(1'b1, 1'b0, w); wsum += w;
      send_bit(1'b0, 1'b0, w); wsum += w;
      send_bit(1'b1, 1'b0, w); wsum += w;
      send_bit(1'b1, 1'b1, w); wsum += w;
      wait_count(n, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL frame_count got=%0d exp=%0d", got_sym.size(), n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (i >= got_sym.size()) begin
            failures++;
            $display("FAIL frame_sym[%0d] got=none exp=%b/%b", i, es[i], el[i]);
         end else if (got_sym[i] !== es[i] || got_last[i] !== el[i]) begin
            failures++;
            $display("FAIL frame_sym[%0d] got=%b/%b exp=%b/%b", i, got_sym[i], got_last[i], es[i], el[i]);
         end
      end
      checks++;
      if (wsum != 0) begin failures++; $display("FAIL frame_stall got=%0d exp=0", wsum); end
      consec = 1'b1;
      for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) consec = 1'b0;
      checks++;
      if (!consec) begin failures++; $display("FAIL frame_gap got=gaps exp=consecutive"); end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  es [11];
      logic [10:0] el;
      int          n;
      int          w;
      int          wsum;
      int          w2;
      int          w2_exp;
      logic        ok;
      logic        consec;
`ifdef CONV_ENC_TAIL_EN
      es = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b11, 2'b11, 2'b10, 2'b11};
      el = 11'b10001000000;
      n  = 11;
      w2_exp = 3;
`else
      es = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      el = 11'b00000011000;
      n  = 5;
      w2_exp = 0;
`endif
      clear_mon();
      sync();
      wsum = 0;
      send_bit(1'b0, 1'b0, w); wsum += w;
      send_bit(1'b1, 1'b0, w); wsum += w;
      send_bit(1'b1, 1'b0, w); wsum += w;
      send_bit(1'b0, 1'b1, w); wsum += w;
      send_bit(1'b1, 1'b1, w2);
      wait_count(n, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_sym.size(), n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (i >= got_sym.size()) begin
            failures++;
            $display("FAIL b2b_sym[%0d] got=none exp=%b/%b", i, es[i], el[i]);
         end else if (got_sym[i] !== es[i] || got_last[i] !== el[i]) begin
            failures++;
            $display("FAIL b2b_sym[%0d] got=%b/%b exp=%b/%b", i, got_sym[i], got_last[i], es[i], el[i]);
         end
      end
      checks++;
      if (wsum != 0) begin failures++; $display("FAIL b2b_stall1 got=%0d exp=0", wsum); end
      checks++;
      if (w2 != w2_exp) begin failures++; $display("FAIL b2b_stall2 got=%0d exp=%0d", w2, w2_exp); end
      consec = 1'b1;
      for (int i = 1; i < got_cyc.size(); i++) if (got_cyc[i] != got_cyc[0] + i) consec = 1'b0;
      checks++;
      if (!consec) begin failures++; $display("FAIL b2b_gap got=gaps exp=consecutive"); end
   endtask

   task automatic test_backpressure();
      logic [1:0] es [7];
      logic [6:0] el;
      int         n;
      logic       ok;
`ifdef CONV_ENC_TAIL_EN
      es = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b01, 2'b11};
      el = 7'b1000000;
      n  = 7;
`else
      es = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
      el = 7'b0001000;
      n  = 4;
`endif
      clear_mon();
      sync();
      fork
         begin
            int w;
            send_bit(1'b1, 1'b0, w);
            send_bit(1'b0, 1'b0, w);
            send_bit(1'b1, 1'b0, w);
            send_bit(1'b1, 1'b1, w);
         end
         begin
            repeat (2) @(posedge clk);
            #1 bus.out_ready = 1'b0;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               checks++;
               if ({bus.out_valid, bus.out_sym, bus.out_last, bus.in_ready} !== 5'b1_11_0_0) begin
                  failures++;
                  $display("FAIL bp_hold[%0d] got v=%b s=%b l=%b rdy=%b exp v=1 s=11 l=0 rdy=0", i, bus.out_valid, bus.out_sym, bus.out_last, bus.in_ready);
               end
               sync();
            end
            bus.out_ready = 1'b1;
         end
      join
      wait_count(n, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", got_sym.size(), n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (i >= got_sym.size()) begin
            failures++;
            $display("FAIL bp_sym[%0d] got=none exp=%b/%b", i, es[i], el[i]);
         end else if (got_sym[i] !== es[i] || got_last[i] !== el[i]) begin
            failures++;
            $display("FAIL bp_sym[%0d] got=%b/%b exp=%b/%b", i, got_sym[i], got_last[i], es[i], el[i]);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] es [4];
      logic [3:0] el;
      int         n;
      int         n_pre;
      int         w;
      logic       ok;
      logic       any_last;
      clear_mon();
      sync();
`ifdef CONV_ENC_TAIL_EN
      es = '{2'b11, 2'b11, 2'b10, 2'b11};
      el = 4'b1000;
      n  = 4;
      n_pre = 2;
      send_bit(1'b1, 1'b1, w);
      sync();
      sync();
`else
      es = '{2'b11, 2'b00, 2'b00, 2'b00};
      el = 4'b0001;
      n  = 1;
      n_pre = 1;
      send_bit(1'b1, 1'b0, w);
      send_bit(1'b0, 1'b0, w);
`endif
      reset = 1'b1;
      sync();
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.in_ready !== 1'b1) begin
         failures++;
         $display("FAIL rst_mid_state got v=%b l=%b rdy=%b exp v=0 l=0 rdy=1", bus.out_valid, bus.out_last, bus.in_ready);
      end
      any_last = 1'b0;
      for (int i = 0; i < got_last.size(); i++) if (got_last[i] !== 1'b0) any_last = 1'b1;
      checks++;
      if (got_sym.size() != n_pre || any_last) begin
         failures++;
         $display("FAIL rst_mid_pre got count=%0d last=%b exp count=%0d last=0", got_sym.size(), any_last, n_pre);
      end
      clear_mon();
      sync();
      send_bit(1'b1, 1'b1, w);
      wait_count(n, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL rst_mid_count got=%0d exp=%0d", got_sym.size(), n); end
      for (int i = 0; i < n; i++) begin
         checks++;
         if (i >= got_sym.size()) begin
            failures++;
            $display("FAIL rst_mid_sym[%0d] got=none exp=%b/%b", i, es[i], el[i]);
         end else if (got_sym[i] !== es[i] || got_last[i] !== el[i]) begin
            failures++;
            $display("FAIL rst_mid_sym[%0d] got=%b/%b exp=%b/%b", i, got_sym[i], got_last[i], es[i], el[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_in_last_ignored();
      test_single_bit();
      test_frame();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/conv_encoder_stream.md
# conv_encoder_stream

Parametrised, streaming convolutional encoder (rate 1/N, constraint length K) with valid/ready handshakes on both sides and per-frame zero-tail termination. It generalises the fixed (2,1,4) encoder: the generator taps, K and N are set by parameters, frames are delimited by `in_last`, and backpressure is supported. It feeds the Viterbi decoder path. With default parameters it produces the same symbols as the existing (2,1,4) encoder.

## Interface
- `K`, 4: constraint length, ≥2. The encoder holds K-1 bits of state.
- `N`, 2: output bits per input bit, ≥1.
- `GEN`, 8'b1111_1101: N*K generator taps. `GEN[j*K +: K]` drives `out_sym[j]`. Tap bit K-1 is the current input; tap bit 0 is the oldest state bit.

- `clk` in 1: clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: input bit valid.
- `in_ready` out 1: encoder can accept an input bit this cycle.
- `in_bit` in 1: data bit.
- `in_last` in 1: final data bit of the frame; qualified by `in_valid`.
- `out_valid` out 1: output symbol valid.
- `out_ready` in 1: downstream accepts the symbol.
- `out_sym` out N: encoded symbol.
- `out_last` out 1: final symbol of the frame (tail included).

## Operation
- Tap window `w = {u, sr}`, where `u` is the encoder input bit and `sr` is the (K-1)-bit shift register.
- `out_sym[j] = ^(GEN[j*K +: K] & w)`.
- On each encode: `sr <= {u, sr[K-2:1]}`.
- FSM states:
  - DATA: `u = in_bit`. An encode happens when `in_valid && in_ready`. If `in_last` is high on that accept, go to TAIL with tail counter = K-1.
  - TAIL: `u = 0`. `in_ready = 0`. One encode per free output slot; decrement the counter on each encode. The encode with counter = 1 sets `out_last` and returns to DATA. `sr` is then all-zero.
- Output register is one symbol deep. A slot is free when `!out_valid || out_ready`.
  - `in_ready = (state == DATA) && free`.
  - An encode loads `out_sym` and `out_last` and sets `out_valid`.
  - If the slot is free and no encode occurs, clear `out_valid`.
- Reset values: `out_valid = 0`, `out_sym = 0`, `out_last = 0`, `in_ready = 1` from the first cycle after reset. `sr = 0`, state = DATA.
- Reset mid-frame or mid-tail discards the frame. No partial `out_last` is emitted.
- Generator check: a tap vector with bit K-1 clear is legal. The implementation must not special-case it.

## Timing
- Latency: input accepted in cycle t → symbol visible in cycle t+1.
- Throughput: one symbol per cycle while `out_ready` is held high.
- A frame of L data bits yields exactly L+K-1 symbols. With defaults there are 3 tail symbols.
- While `out_valid && !out_ready`, `out_sym` and `out_last` are held stable and `in_ready = 0`.
- The first bit of the next frame can be accepted in the same cycle the `out_last` symbol is accepted downstream.
- Single-bit frame (`in_last` on the first bit) is legal. The first tail encode occurs on the cycle after the data bit is accepted, if the slot is free.
- `in_last` without `in_valid` is ignored.

## Configuration
- `CONV_ENC_TAIL_EN` defined: zero-tail termination as described above.
- `CONV_ENC_TAIL_EN` undefined:
  - No TAIL state.
  - The `in_last` accept sets `out_last` on that same data symbol and clears `sr` to zero after the encode.
  - A frame yields exactly L symbols.

## Structure
- `conv_enc_pkg` holds:
  - FSM state enum (DATA, TAIL).
  - Default generator constant `CONV_GEN_K4_N2 = 8'b1111_1101`.
  - Tail-counter width helper `$clog2(K)`.
- Sub-module `conv_enc_parity`: combinational; takes the K-bit window and `GEN`, produces the N-bit symbol. Instantiated once.

## Test plan
All scenarios use defaults with `CONV_ENC_TAIL_EN` defined unless noted.
- Reset: hold `reset` 2 cycles, release → `out_valid=0`, `out_sym=00`, `out_last=0`, `in_ready=1`.
- Single-bit frame: `in_bit=1`, `in_last=1`, `out_ready=1` → symbols 11, 11, 10, 11 on consecutive cycles; `out_last` only on the 4th; `in_ready=0` for 3 cycles.
- Frame 1,0,1,1 with `in_last` on the 4th bit, `out_ready=1` → 11, 11, 01, 11, 01, 01, 11; `out_last` on the 7th; the next frame starts from `sr=000`.
- Backpressure: drop `out_ready` for 3 cycles mid-frame → `out_sym` held stable, `in_ready=0`, no symbol lost or duplicated; the sequence matches the previous scenario.
- Reset during TAIL (after 1 tail symbol) → next cycle `out_valid=0`; a new single-bit-1 frame yields 11, 11, 10, 11.
- `CONV_ENC_TAIL_EN` undefined: frames "1" then "1" → 11 (`out_last`), then 11 (`out_last`); `in_ready` never drops while `out_ready=1`.
